rx_crc16_check: RTL

RX_CRC16_CHECK -- requirements
Module: rx_crc16_check

---
 rtl/rx_crc16_check.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_crc16_check.sv
// ---------------------------------------------------------------------------
// rx_crc16_check
//
// This block checks the USB CRC16 on a received DATA field. It receives the
// destuffed payload bits one at a time, including the trailing CRC field.
// It runs the CRC16 shift register (polynomial 0x8005, initial value 0xFFFF).
// At end of packet it issues one verdict: CRC good or bad, byte misalignment,
// and a length that is out of range.
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   pkt_start  in   one-cycle pulse on the first cycle of a data field
//   bit_valid  in   bit_in carries a payload bit this cycle
//   bit_in     in   payload bit, LSB-first per byte, CRC field included
//   pkt_end    in   one-cycle pulse at EOP; a bit_valid in the same cycle
//                   counts as the last bit
//   busy       out  high while a packet is being received
//   check_done out  one-cycle pulse when the verdict is issued
//   crc_ok     out  residual matched and no framing error (held)
//   crc_err    out  residual mismatch or any framing error (held)
//   align_err  out  bit count not a multiple of 8 (held)
//   len_err    out  bit count < 16 or > 8200 (held)
//   bit_count  out  payload bits accepted, saturating at 16383
//
// Optional build: define RX_CRC16_STATS_EN to add the good_cnt[7:0] and
// bad_cnt[7:0] packet counters. Both saturate at 255.
//
// States
//   IDLE | waiting for pkt_start
//   RUN  | accepting payload bits
//   DONE | verdict cycle (check_done high), returns to IDLE
// ---------------------------------------------------------------------------
module rx_crc16_check (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        pkt_start,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        pkt_end,
  output logic        busy,
  output logic        check_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        align_err,
  output logic        len_err,
  output logic [13:0] bit_count
`ifdef RX_CRC16_STATS_EN
  ,
  output logic [7:0]  good_cnt,
  output logic [7:0]  bad_cnt
`endif
);

  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8005;
  localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
  localparam logic [13:0] CNT_MAX      = 14'h3FFF;
  localparam logic [13:0] LEN_MIN      = 14'd16;
  localparam logic [13:0] LEN_MAX      = 14'd8200;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] crc_r;
  logic [15:0] crc_nxt;
  logic [15:0] crc_shift;
  logic [13:0] cnt_nxt;
  logic [13:0] cnt_inc;
  logic        fb;
  logic        init;
  logic        shift_en;
  logic        issue;

  logic        busy_nxt;
  logic        done_nxt;
  logic        ok_nxt;
  logic        err_nxt;
  logic        align_nxt;
  logic        len_nxt;
  logic        align_chk;
  logic        len_chk;
  logic        res_chk;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. While in RUN, pkt_start has priority over pkt_end:
  // the packet is aborted and restarted, so no verdict is issued for it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pkt_start) begin
          state_nxt = pkt_end ? DONE : RUN;
        end
      end
      RUN: begin
        if (!pkt_start && pkt_end) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values. A bit that arrives on a pkt_start cycle is never
  // counted, because that cycle re-initialises the packet.
  always_comb begin
    init      = pkt_start && (state != DONE);
    shift_en  = (state == RUN) && bit_valid && !pkt_start;
    fb        = bit_in ^ crc_r[15];
    crc_shift = {crc_r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    cnt_inc   = (bit_count == CNT_MAX) ? bit_count : bit_count + 14'd1;

    crc_nxt = crc_r;
    cnt_nxt = bit_count;
    if (init) begin
      crc_nxt = CRC_INIT;
      cnt_nxt = '0;
    end else if (shift_en) begin
      crc_nxt = crc_shift;
      cnt_nxt = cnt_inc;
    end
  end

  // Output next values. The verdict is evaluated on the post-update register
  // and count, so the last bit on the pkt_end cycle is included. The verdict
  // is registered on the same edge that enters DONE, which places check_done
  // exactly one cycle after pkt_end.
  always_comb begin
    issue     = (state_nxt == DONE) && (state != DONE);
    res_chk   = (crc_nxt == CRC_RESIDUAL);
    align_chk = (cnt_nxt[2:0] != 3'd0);
    len_chk   = (cnt_nxt < LEN_MIN) || (cnt_nxt > LEN_MAX);

    busy_nxt  = (state_nxt == RUN);
    done_nxt  = issue;
    ok_nxt    = crc_ok;
    err_nxt   = crc_err;
    align_nxt = align_err;
    len_nxt   = len_err;

    if (issue) begin
      ok_nxt    = res_chk && !align_chk && !len_chk;
      err_nxt   = !(res_chk && !align_chk && !len_chk);
      align_nxt = align_chk;
      len_nxt   = len_chk;
    end else if (init) begin
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      align_nxt = 1'b0;
      len_nxt   = 1'b0;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_r      <= CRC_INIT;
      bit_count  <= '0;
      busy       <= 1'b0;
      check_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      align_err  <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      crc_r      <= crc_nxt;
      bit_count  <= cnt_nxt;
      busy       <= busy_nxt;
      check_done <= done_nxt;
      crc_ok     <= ok_nxt;
      crc_err    <= err_nxt;
      align_err  <= align_nxt;
      len_err    <= len_nxt;
    end
  end

`ifdef RX_CRC16_STATS_EN
  // The counters update on the same edge as check_done, so they already
  // include the packet in the cycle where its verdict is shown.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (done_nxt) begin
      if (ok_nxt) begin
        if (good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
      end else begin
        if (bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
